// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and state type for the memory responder.
// Rev 1.0
`default_nettype none

package mem_pkg;

    localparam logic [1:0]  SIZE_B   = 2'b00;
    localparam logic [1:0]  SIZE_H   = 2'b01;
    localparam logic [1:0]  SIZE_W   = 2'b10;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_D = 2'd1,
        ACC_I = 2'd2
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  lane_mask = 4'b0001 << off;
            SIZE_H:  lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// mem_array: single-port synchronous word RAM with byte enables, read-first, no reset.
// Rev 1.0
`default_nettype none

module mem_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// mem_responder: arbitrates fetch and data requests onto one RAM with wait states.
// Rev 1.0
`default_nettype none

module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        i_iReq,
    input  logic [31:0] i_iAddr,
    output logic [31:0] o_iRdata,
    output logic        o_iValid,
    output logic        o_iBusy,
    input  logic        i_dReq,
    input  logic        i_dWe,
    input  logic [1:0]  i_dSize,
    input  logic [31:0] i_dAddr,
    input  logic [31:0] i_dWdata,
    output logic [31:0] o_dRdata,
    output logic        o_dValid,
    output logic        o_dBusy,
    output logic        o_dErr
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          CW        = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);
    localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    state_t         state;
    logic [CW-1:0]  count;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic [1:0]     size;
    logic           we;
    logic           i_valid, d_valid, d_err, i_nop;
    logic [31:0]    i_hold, d_hold;

    logic           in_range, misalign, d_bad, i_bad, fire;
    logic [AW-1:0]  index;
    logic [3:0]     ram_be;
    logic [31:0]    ram_wdata, ram_q;

    assign in_range = (addr >= BASE_ADDR) && ({1'b0, addr} < LIMIT);
    assign index    = AW'((addr - BASE_ADDR) >> 2);

    always_comb begin
        misalign  = 1'b1;
        ram_wdata = wdata;
        case (size)
            SIZE_B: begin misalign = 1'b0;           ram_wdata = {4{wdata[7:0]}};  end
            SIZE_H: begin misalign = addr[0];        ram_wdata = {2{wdata[15:0]}}; end
            SIZE_W: begin misalign = addr[1:0] != 2'b00;                           end
            default: misalign = 1'b1;
        endcase
    end

    assign d_bad  = !in_range || misalign;
    assign i_bad  = !in_range || (addr[1:0] != 2'b00);
    assign fire   = (state != IDLE) && (count == '0);
    // Writes are committed only on the final wait cycle, so an aborted access never touches RAM.
    assign ram_be = (fire && state == ACC_D && we && !d_bad) ? lane_mask(size, addr[1:0]) : 4'b0000;

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (fire),
        .be    (ram_be),
        .addr  (index),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state   <= IDLE;
            count   <= '0;
            addr    <= '0;
            wdata   <= '0;
            size    <= SIZE_W;
            we      <= 1'b0;
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            d_err   <= 1'b0;
            i_nop   <= 1'b0;
            i_hold  <= '0;
            d_hold  <= '0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            d_err   <= 1'b0;
            if (i_valid) i_hold <= o_iRdata;
            if (d_valid) d_hold <= o_dRdata;
            case (state)
                IDLE: begin
                    // A port whose valid is high this cycle is still holding its old request.
                    if (i_dReq && !d_valid) begin
                        addr  <= i_dAddr;
                        size  <= i_dSize;
                        we    <= i_dWe;
                        wdata <= i_dWdata;
                        count <= WAIT_INIT;
                        state <= ACC_D;
                    end else if (i_iReq && !i_valid) begin
                        addr  <= i_iAddr;
                        we    <= 1'b0;
                        count <= WAIT_INIT;
                        state <= ACC_I;
                    end
                end
                ACC_D: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        d_valid <= 1'b1;
                        d_err   <= d_bad;
                        state   <= IDLE;
                    end
                end
                ACC_I: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        i_valid <= 1'b1;
                        i_nop   <= i_bad;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_iRdata = i_valid ? (i_nop ? NOP_INST : ram_q) : i_hold;
    assign o_dRdata = d_valid ? (d_err ? 32'h0 : ram_q) : d_hold;
    assign o_iValid = i_valid;
    assign o_dValid = d_valid;
    assign o_dErr   = d_err;
    assign o_iBusy  = i_iReq & ~i_valid;
    assign o_dBusy  = i_dReq & ~d_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed table-driven bench for mem_responder.
// Rev 1.0
`default_nettype none

module tb_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_x = 1'b1;
    logic        iReq, dReq, dWe, dReq0, dReq3;
    logic [1:0]  dSize;
    logic [31:0] iAddr, dAddr, dWdata;
    logic [31:0] iRdata, dRdata;
    logic        iValid, iBusy, dValid, dBusy, dErr;
    logic [31:0] iRdata0, dRdata0, iRdata3, dRdata3;
    logic        iValid0, iBusy0, dValid0, dBusy0, dErr0;
    logic        iValid3, iBusy3, dValid3, dBusy3, dErr3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset_x(reset_x),
        .i_iReq(iReq), .i_iAddr(iAddr), .o_iRdata(iRdata), .o_iValid(iValid), .o_iBusy(iBusy),
        .i_dReq(dReq), .i_dWe(dWe), .i_dSize(dSize), .i_dAddr(dAddr), .i_dWdata(dWdata),
        .o_dRdata(dRdata), .o_dValid(dValid), .o_dBusy(dBusy), .o_dErr(dErr)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_x(reset_x),
        .i_iReq(1'b0), .i_iAddr(iAddr), .o_iRdata(iRdata0), .o_iValid(iValid0), .o_iBusy(iBusy0),
        .i_dReq(dReq0), .i_dWe(dWe), .i_dSize(dSize), .i_dAddr(dAddr), .i_dWdata(dWdata),
        .o_dRdata(dRdata0), .o_dValid(dValid0), .o_dBusy(dBusy0), .o_dErr(dErr0)
    );

    mem_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset_x(reset_x),
        .i_iReq(1'b0), .i_iAddr(iAddr), .o_iRdata(iRdata3), .o_iValid(iValid3), .o_iBusy(iBusy3),
        .i_dReq(dReq3), .i_dWe(dWe), .i_dSize(dSize), .i_dAddr(dAddr), .i_dWdata(dWdata),
        .o_dRdata(dRdata3), .o_dValid(dValid3), .o_dBusy(dBusy3), .o_dErr(dErr3)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        iReq = 1'b0; dReq = 1'b0; dReq0 = 1'b0; dReq3 = 1'b0;
        reset_x = 1'b0;
        repeat (2) tick;
        reset_x = 1'b1;
        tick;
    endtask

    task automatic d_access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic err, output int lat);
        dWe = we; dSize = sz; dAddr = a; dWdata = wd; dReq = 1'b1;
        lat = -1; rd = 32'h0; err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (dValid) begin
                lat = k; rd = dRdata; err = dErr;
                break;
            end
        end
        dReq = 1'b0;
        tick;
    endtask

    task automatic i_access(input logic [31:0] a, output logic [31:0] rd, output int lat);
        iAddr = a; iReq = 1'b1; lat = -1; rd = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (iValid) begin
                lat = k; rd = iRdata;
                break;
            end
        end
        iReq = 1'b0;
        tick;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat, dv_at, iv_at, first0, first3, cnt0, cnt3, vcount;
        logic        prev0, prev3, dbl0, dbl3;

        vecs[0]  = '{1'b1, SIZE_W, 32'h0001_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, SIZE_B, 32'h0001_0011, 32'h0000_00AA, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, SIZE_W, 32'h0001_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_AAEF};
        vecs[3]  = '{1'b1, SIZE_H, 32'h0001_0012, 32'h0000_1234, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, SIZE_W, 32'h0001_0010, 32'h0,         1'b0, 1'b1, 32'h1234_AAEF};
        vecs[5]  = '{1'b1, SIZE_H, 32'h0001_0011, 32'h0000_FFFF, 1'b1, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, SIZE_W, 32'h0001_0002, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, SIZE_W, 32'h0000_FFFC, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, SIZE_W, 32'h0001_0010, 32'h0,         1'b0, 1'b1, 32'h1234_AAEF};
        vecs[9]  = '{1'b0, 2'b11,  32'h0001_0010, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[10] = '{1'b1, SIZE_W, 32'h0001_3FFC, 32'h0000_0055, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, SIZE_W, 32'h0001_4000, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[12] = '{1'b0, SIZE_W, 32'h0001_3FFC, 32'h0,         1'b0, 1'b1, 32'h0000_0055};
        vecs[13] = '{1'b0, SIZE_B, 32'h0001_0013, 32'h0,         1'b0, 1'b1, 32'h1234_AAEF};
        vecs[14] = '{1'b0, SIZE_W, 32'h0001_0000, 32'h0,         1'b0, 1'b1, 32'h0050_0093};
        vecs[15] = '{1'b1, 2'b11,  32'h0001_0010, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[16] = '{1'b0, SIZE_W, 32'h0001_0010, 32'h0,         1'b0, 1'b1, 32'h1234_AAEF};

        iReq = 1'b0; dReq = 1'b0; dReq0 = 1'b0; dReq3 = 1'b0; dWe = 1'b0;
        dSize = SIZE_W; iAddr = 32'h0; dAddr = 32'h0; dWdata = 32'h0;
        #2 reset_x = 1'b0;
        tick;
        check("reset iValid", {31'h0, iValid}, 32'h0);
        check("reset dValid", {31'h0, dValid}, 32'h0);
        check("reset dErr",   {31'h0, dErr},   32'h0);
        check("reset iRdata", iRdata, 32'h0);
        check("reset dRdata", dRdata, 32'h0);
        reset_x = 1'b1;
        tick;

        // Preload word 0, then reset: RAM contents must survive reset.
        d_access(1'b1, SIZE_W, 32'h0001_0000, 32'h0050_0093, rd, err, lat);
        check("preload err", {31'h0, err}, 32'h0);
        do_reset;

        i_access(32'h0001_0000, rd, lat);
        check("fetch latency", lat, 32'd3);
        check("fetch data", rd, 32'h0050_0093);
        i_access(32'h0001_0002, rd, lat);
        check("fetch misaligned nop", rd, NOP_INST);
        i_access(32'h0000_FFFC, rd, lat);
        check("fetch below base nop", rd, NOP_INST);
        i_access(32'h0001_4000, rd, lat);
        check("fetch above top nop", rd, NOP_INST);

        for (int v = 0; v < 17; v++) begin
            d_access(vecs[v].we, vecs[v].size, vecs[v].addr, vecs[v].wdata, rd, err, lat);
            check($sformatf("vec%0d latency", v), lat, 32'd3);
            check($sformatf("vec%0d err", v), {31'h0, err}, {31'h0, vecs[v].err});
            if (vecs[v].chk_rd) check($sformatf("vec%0d rdata", v), rd, vecs[v].rdata);
        end

        // Simultaneous fetch and load: data first, fetch right after.
        iAddr = 32'h0001_0000; dWe = 1'b0; dSize = SIZE_W; dAddr = 32'h0001_0010;
        iReq = 1'b1; dReq = 1'b1; dv_at = -1; iv_at = -1;
        #1;
        check("both busy i", {31'h0, iBusy}, 32'h1);
        check("both busy d", {31'h0, dBusy}, 32'h1);
        for (int k = 1; k <= 15; k++) begin
            tick;
            if (dValid && dv_at < 0) begin
                dv_at = k;
                check("arb d rdata", dRdata, 32'h1234_AAEF);
                check("arb d busy at valid", {31'h0, dBusy}, 32'h0);
                check("arb i busy at d valid", {31'h0, iBusy}, 32'h1);
                dReq = 1'b0;
            end
            if (iValid && iv_at < 0) begin
                iv_at = k;
                check("arb i rdata", iRdata, 32'h0050_0093);
                iReq = 1'b0;
            end
        end
        check("arb d valid cycle", dv_at, 32'd3);
        check("arb i valid cycle", iv_at, 32'd6);
        iReq = 1'b0; dReq = 1'b0;
        tick;

        // Reset during a store's wait state: no pulse, no write.
        dWe = 1'b1; dSize = SIZE_W; dAddr = 32'h0001_0010; dWdata = 32'h1111_1111; dReq = 1'b1;
        tick;
        reset_x = 1'b0; dReq = 1'b0;
        vcount = 0;
        tick;
        if (dValid) vcount++;
        reset_x = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (dValid) vcount++;
        end
        check("abort no valid", vcount, 32'd0);
        d_access(1'b0, SIZE_W, 32'h0001_0010, 32'h0, rd, err, lat);
        check("abort readback", rd, 32'h1234_AAEF);
        check("abort idle latency", lat, 32'd3);

        // Wait-state sweep with requests held continuously.
        dWe = 1'b0; dSize = SIZE_W; dAddr = 32'h0001_0000;
        dReq0 = 1'b1; dReq3 = 1'b1;
        first0 = -1; first3 = -1; cnt0 = 0; cnt3 = 0;
        prev0 = 1'b0; prev3 = 1'b0; dbl0 = 1'b0; dbl3 = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tick;
            if (dValid0) begin
                if (first0 < 0) first0 = k;
                cnt0++;
                if (prev0) dbl0 = 1'b1;
            end
            if (dValid3) begin
                if (first3 < 0) first3 = k;
                cnt3++;
                if (prev3) dbl3 = 1'b1;
            end
            prev0 = dValid0;
            prev3 = dValid3;
        end
        dReq0 = 1'b0; dReq3 = 1'b0;
        repeat (8) tick;
        check("w0 first valid", first0, 32'd2);
        check("w3 first valid", first3, 32'd5);
        check("w0 pulse count", cnt0, 32'd6);
        check("w3 pulse count", cnt3, 32'd3);
        check("w0 no double", {31'h0, dbl0}, 32'h0);
        check("w3 no double", {31'h0, dbl3}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
